vec_exe_mem_pipe: RTL and testbench
===================================

Name: vec_exe_mem_pipe

Overview:
- Parametrised successor to the fixed 4-lane EXE/MEM back end of the vector pixel CPU.
- Takes decoded vector ops of LANES lanes, WIDTH bits each: pixel vector, constant vector, function code, WOM write flag and address.
- Executes per lane in stage E, registers results in stage M, and presents them to memory/writeback over a valid/ready handshake.
- Adds behaviour the fixed pipeline lacks: backpressure stall, flush, per-lane MAC accumulators and a retire counter.

Parameters:
- LANES, 4, number of vector lanes (1..16).
- WIDTH, 32, bits per lane element (8..32).
- ADDR_W, 32, width of WOM address.
- CNT_W, 16, width of retire counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight ops (synchronous).
- in_valid  in  1  input op valid.
- in_ready  out  1  block can accept op this cycle.
- in_func  in  2  00 ADD, 01 MUL, 10 MAC, 11 CLR.
- in_pix  in  LANES*WIDTH  pixel vector; lane k = bits [k*WIDTH +: WIDTH].
- in_cte  in  LANES*WIDTH  constant vector, same packing.
- in_wr_wom  in  1  op writes WOM.
- in_wom_addr  in  ADDR_W  WOM address.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_res  out  LANES*WIDTH  result vector.
- out_wr_wom  out  1  WOM write flag of result op.
- out_wom_addr  out  ADDR_W  WOM address of result op.
- retired  out  CNT_W  count of ops handed off at output.

Behaviour:
Reset (rst=1 at edge):
- e_valid=0, m_valid=0, out_valid=0.
- out_res=0, out_wr_wom=0, out_wom_addr=0, retired=0.
- All lane accumulators = 0.
- In-flight ops are discarded. rst has priority over flush and over every handshake.

Handshake:
- m_adv = !m_valid || out_ready.
- e_adv = !e_valid || m_adv.
- in_ready = e_adv (combinational; no in_valid → in_ready path).
- An op is accepted when in_valid && in_ready.
- An op moves E→M when e_valid && m_adv.
- An op retires when out_valid && out_ready.
- While out_valid=1 && out_ready=0, out_* stay stable.

Latency:
- Accept at edge N → out_valid=1 after edge N+2 when unstalled.
- Throughput 1 op/cycle.

Stage E (on accept):
- Computes lane results combinationally from in_*.
- Registers result, wr_wom and addr.
- ADD: (pix+cte) mod 2^WIDTH.
- MUL: low WIDTH bits of the 2*WIDTH product.
- MAC: acc_k <= acc_k + pix_k*cte_k, truncated to WIDTH; result = new acc_k.
- CLR: acc_k <= 0; result = 0.
- Accumulators update only on accept, never on a stall cycle.
- A MAC directly after a MAC uses the updated acc (no hazard bubble).

Stage M:
- Plain register copy of stage E when m_adv.
- out_* are driven from the M registers.

Retire counter:
- retired increments on each retire and wraps 2^CNT_W-1 → 0.

Flush:
- flush=1 at edge clears e_valid and m_valid; out_valid=0 next cycle.
- An op offered in the same cycle is not accepted: in_ready is forced to 0 while flush=1.
- Accumulator updates already made by flushed ops are kept.
- retired does not count a result flushed while out_ready=1 in the same cycle.

Boundaries:
- Both stages full and out_ready=0 → in_ready=0.
- Both stages full, out_ready=1 and in_valid=1 in the same cycle → retire, shift and accept all occur; occupancy stays 2.
- Reset during a stall clears everything; out_valid=0 next cycle.

Optional Feature:
- Macro: VEC_EXE_MEM_SAT_EN.
- Defined: ADD, MUL and MAC results use unsigned saturation, clipped to 2^WIDTH-1 instead of wrapping. The MAC accumulator stores the saturated value.
- Undefined: modulo-2^WIDTH wrap as above.
- Handshake, latency and counters are identical in both builds.

Test Plan:
- Reset, then ADD with pix lanes {1,2,3,4}, cte {10,20,30,40}, out_ready=1 → out_valid two cycles after accept; out_res {11,22,33,44}; retired=1.
- MUL with WIDTH=32, pix=0x0001_0000, cte=0x0001_0000 in all lanes → wrap build gives 0; VEC_EXE_MEM_SAT_EN build gives 0xFFFF_FFFF.
- CLR, then MAC ×3 with pix=2, cte=3, back-to-back → results 6, 12, 18 per lane; a following CLR returns 0.
- Hold out_ready=0 and offer 3 ops → first two accepted; in_ready=0 on the third; out_res stable. Release out_ready → all three retire in order; retired=3.
- Two ops in flight, pulse flush → out_valid=0 next cycle; a MAC accumulator already updated keeps its value; retired unchanged.
- Assert rst mid-stream with out_ready=0 → all outputs 0 next cycle; a MAC after reset starts from acc=0.

Source files
------------

// File: rtl/vec_exe_mem_pipe.sv
// vec_exe_mem_pipe: parametrised LANES x WIDTH vector EXE/MEM back end.
// Stage E computes per-lane ADD/MUL/MAC/CLR on accept. Stage M holds the result
// for a valid/ready hand-off. Includes flush, per-lane MAC accumulators and a
// retire counter.
// Optional feature: define VEC_EXE_MEM_SAT_EN for unsigned saturating
// ADD/MUL/MAC instead of modulo-2^WIDTH wrap.
module vec_exe_mem_pipe #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             in_func_i,
  input  logic [LANES*WIDTH-1:0] in_pix_i,
  input  logic [LANES*WIDTH-1:0] in_cte_i,
  input  logic                   in_wr_wom_i,
  input  logic [ADDR_W-1:0]      in_wom_addr_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*WIDTH-1:0] out_res_o,
  output logic                   out_wr_wom_o,
  output logic [ADDR_W-1:0]      out_wom_addr_o,
  output logic [CNT_W-1:0]       retired_o
);

  localparam int unsigned VecW = LANES * WIDTH;

  localparam logic [1:0] FuncAdd = 2'b00;
  localparam logic [1:0] FuncMul = 2'b01;
  localparam logic [1:0] FuncMac = 2'b10;
  localparam logic [1:0] FuncClr = 2'b11;

  logic              e_valid_q, m_valid_q;
  logic [VecW-1:0]   e_res_d, e_res_q, m_res_q;
  logic              e_wr_q, m_wr_q;
  logic [ADDR_W-1:0] e_addr_q, m_addr_q;
  logic [CNT_W-1:0]  retired_q;

  logic m_adv, e_adv, accept, retire;

  assign m_adv      = !m_valid_q || out_ready_i;
  assign e_adv      = !e_valid_q || m_adv;
  assign in_ready_o = e_adv && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  // A result killed by flush is not counted even if the consumer was ready.
  assign retire     = m_valid_q && out_ready_i && !flush_i;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] pix, cte, acc_q;
    logic [WIDTH-1:0] add_r, mul_r, mac_r, lane_res;

    assign pix = in_pix_i[k*WIDTH +: WIDTH];
    assign cte = in_cte_i[k*WIDTH +: WIDTH];

`ifdef VEC_EXE_MEM_SAT_EN
    logic [WIDTH:0]     add_full;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH:0]   mac_full;

    assign add_full = {1'b0, pix} + {1'b0, cte};
    assign prod     = {{WIDTH{1'b0}}, pix} * {{WIDTH{1'b0}}, cte};
    assign mac_full = {{(WIDTH+1){1'b0}}, acc_q} + {1'b0, prod};
    assign add_r    = add_full[WIDTH] ? '1 : add_full[WIDTH-1:0];
    assign mul_r    = (|prod[2*WIDTH-1:WIDTH]) ? '1 : prod[WIDTH-1:0];
    assign mac_r    = (|mac_full[2*WIDTH:WIDTH]) ? '1 : mac_full[WIDTH-1:0];
`else
    // Low WIDTH bits of the product do not depend on the upper operand bits.
    assign add_r = pix + cte;
    assign mul_r = pix * cte;
    assign mac_r = acc_q + mul_r;
`endif

    // Lane result select by function code.
    always_comb begin
      lane_res = '0;
      case (in_func_i)
        FuncAdd: lane_res = add_r;
        FuncMul: lane_res = mul_r;
        FuncMac: lane_res = mac_r;
        FuncClr: lane_res = '0;
        default: lane_res = '0;
      endcase
    end

    assign e_res_d[k*WIDTH +: WIDTH] = lane_res;

    // Accumulator moves only on accept, so stalls never double-count a MAC.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        acc_q <= '0;
      end else if (accept && (in_func_i == FuncMac)) begin
        acc_q <= mac_r;
      end else if (accept && (in_func_i == FuncClr)) begin
        acc_q <= '0;
      end
    end
  end

  // Stage E register: loads on accept, empties when its op moves on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_valid_q <= 1'b0;
      e_res_q   <= '0;
      e_wr_q    <= 1'b0;
      e_addr_q  <= '0;
    end else if (flush_i) begin
      e_valid_q <= 1'b0;
    end else if (e_adv) begin
      e_valid_q <= accept;
      if (accept) begin
        e_res_q  <= e_res_d;
        e_wr_q   <= in_wr_wom_i;
        e_addr_q <= in_wom_addr_i;
      end
    end
  end

  // Stage M register: copies stage E whenever the output slot is free or draining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      m_res_q   <= '0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
    end else if (flush_i) begin
      m_valid_q <= 1'b0;
    end else if (m_adv) begin
      m_valid_q <= e_valid_q;
      if (e_valid_q) begin
        m_res_q  <= e_res_q;
        m_wr_q   <= e_wr_q;
        m_addr_q <= e_addr_q;
      end
    end
  end

  // Retire counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign out_valid_o    = m_valid_q;
  assign out_res_o      = m_res_q;
  assign out_wr_wom_o   = m_wr_q;
  assign out_wom_addr_o = m_addr_q;
  assign retired_o      = retired_q;

endmodule

// File: tb/tb_vec_exe_mem_pipe.sv
// Directed self-checking bench for vec_exe_mem_pipe (LANES=4, WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_vec_exe_mem_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_func = 2'b00;
  logic [127:0] in_pix = '0;
  logic [127:0] in_cte = '0;
  logic         in_wr_wom = 1'b0;
  logic [31:0]  in_wom_addr = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_res;
  logic         out_wr_wom;
  logic [31:0]  out_wom_addr;
  logic [15:0]  retired;

  int vectors = 0;
  int miscompares = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  vec_exe_mem_pipe dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_func_i      (in_func),
    .in_pix_i       (in_pix),
    .in_cte_i       (in_cte),
    .in_wr_wom_i    (in_wr_wom),
    .in_wom_addr_i  (in_wom_addr),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_res_o      (out_res),
    .out_wr_wom_o   (out_wr_wom),
    .out_wom_addr_o (out_wom_addr),
    .retired_o      (retired)
  );

  function automatic logic [127:0] splat(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [127:0] vec4(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] f, input logic [127:0] p, input logic [127:0] c,
                       input logic wr, input logic [31:0] a);
    in_valid = 1'b1;
    in_func = f;
    in_pix = p;
    in_cte = c;
    in_wr_wom = wr;
    in_wom_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    vectors++;
    if (out_res !== '0) begin
      miscompares++;
      $display("FAIL reset_out_res got %h want 0", out_res);
    end
    vectors++;
    if (retired !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_retired got %0d want 0", retired);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    offer(2'b00, vec4(1, 2, 3, 4), vec4(10, 20, 30, 40), 1'b1, 32'hA5A5_0010);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_latency_early got %0b want 0", out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL add_out_valid got %0b want 1", out_valid);
    end
    vectors++;
    if (out_res !== vec4(11, 22, 33, 44)) begin
      miscompares++;
      $display("FAIL add_out_res got %h want %h", out_res, vec4(11, 22, 33, 44));
    end
    vectors++;
    if (out_wr_wom !== 1'b1 || out_wom_addr !== 32'hA5A5_0010) begin
      miscompares++;
      $display("FAIL add_wom got %0b/%h want 1/a5a50010", out_wr_wom, out_wom_addr);
    end
    step();
    exp_ret++;
    vectors++;
    if (out_valid !== 1'b0 || retired !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL add_retire got valid=%0b retired=%0d want 0/%0d", out_valid, retired,
               exp_ret);
    end
  endtask

  task automatic test_mul();
    logic [127:0] exp;
`ifdef VEC_EXE_MEM_SAT_EN
    exp = splat(32'hFFFF_FFFF);
`else
    exp = splat(32'h0000_0000);
`endif
    out_ready = 1'b1;
    offer(2'b01, splat(32'h0001_0000), splat(32'h0001_0000), 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== exp) begin
      miscompares++;
      $display("FAIL mul_overflow got valid=%0b res=%h want 1/%h", out_valid, out_res, exp);
    end
    vectors++;
    if (out_wr_wom !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_wr_wom got %0b want 0", out_wr_wom);
    end
    step();
    exp_ret++;
  endtask

  task automatic test_mac_chain();
    logic [1:0]  funcs [5];
    logic [31:0] exps  [5];
    funcs = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    exps  = '{32'd0, 32'd6, 32'd12, 32'd18, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(funcs[i], splat(32'd2), splat(32'd3), 1'b0, 32'(i));
      step();
      if (i >= 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_res !== splat(exps[i-1])) begin
          miscompares++;
          $display("FAIL mac_chain_%0d got valid=%0b res=%h want 1/%h", i - 1, out_valid,
                   out_res, splat(exps[i-1]));
        end
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== splat(exps[4])) begin
      miscompares++;
      $display("FAIL mac_chain_4 got valid=%0b res=%h want 1/0", out_valid, out_res);
    end
    step();
    exp_ret += 5;
    vectors++;
    if (retired !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL mac_chain_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(2'b00, splat(32'd1), splat(32'd100), 1'b1, 32'h100);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready0 got %0b want 1", in_ready);
    end
    step();
    offer(2'b00, splat(32'd2), splat(32'd100), 1'b0, 32'h200);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready1 got %0b want 1", in_ready);
    end
    step();
    offer(2'b00, splat(32'd3), splat(32'd100), 1'b1, 32'h300);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready_full got %0b want 0", in_ready);
    end
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== splat(32'd101) || out_wom_addr !== 32'h100 ||
        in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stable got valid=%0b res=%h addr=%h rdy=%0b want 1/%h/100/0",
               out_valid, out_res, out_wom_addr, in_ready, splat(32'd101));
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready got %0b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_res !== splat(32'd102) || retired !== 16'(exp_ret + 1)) begin
      miscompares++;
      $display("FAIL bp_second got res=%h retired=%0d want %h/%0d", out_res, retired,
               splat(32'd102), exp_ret + 1);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== splat(32'd103) || out_wom_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL bp_third got valid=%0b res=%h addr=%h want 1/%h/300", out_valid,
               out_res, out_wom_addr, splat(32'd103));
    end
    step();
    exp_ret += 3;
    vectors++;
    if (out_valid !== 1'b0 || retired !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL bp_retired got valid=%0b retired=%0d want 0/%0d", out_valid, retired,
               exp_ret);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(2'b11, splat(32'd0), splat(32'd0), 1'b0, 32'h0);
    step();
    offer(2'b10, splat(32'd2), splat(32'd5), 1'b0, 32'h0);
    step();
    // Both stages full; acc is now 10. Flush while offering and while out_ready=1.
    offer(2'b00, splat(32'd7), splat(32'd7), 1'b1, 32'hDEAD);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready got %0b want 0", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || retired !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL flush_cleared got valid=%0b retired=%0d want 0/%0d", out_valid, retired,
               exp_ret);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_ghost got %0b want 0", out_valid);
    end
    offer(2'b10, splat(32'd1), splat(32'd1), 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== splat(32'd11)) begin
      miscompares++;
      $display("FAIL flush_acc_kept got valid=%0b res=%h want 1/%h", out_valid, out_res,
               splat(32'd11));
    end
    step();
    exp_ret++;
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    offer(2'b10, splat(32'd3), splat(32'd3), 1'b1, 32'h55);
    step();
    offer(2'b10, splat(32'd3), splat(32'd3), 1'b1, 32'h66);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ret = 0;
    vectors++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_wr_wom !== 1'b0 ||
        out_wom_addr !== '0 || retired !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid got valid=%0b res=%h wr=%0b addr=%h ret=%0d want all 0",
               out_valid, out_res, out_wr_wom, out_wom_addr, retired);
    end
    out_ready = 1'b1;
    offer(2'b10, splat(32'd2), splat(32'd4), 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_res !== splat(32'd8)) begin
      miscompares++;
      $display("FAIL rst_mac_from_zero got valid=%0b res=%h want 1/%h", out_valid, out_res,
               splat(32'd8));
    end
    step();
    exp_ret++;
    vectors++;
    if (retired !== 16'(exp_ret)) begin
      miscompares++;
      $display("FAIL rst_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mac_chain();
    test_backpressure();
    test_flush();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
